// File: rtl/uart_rx_pkg.sv
// Shared definitions for the J1 UART receive peripheral: receiver FSM states,
// bus register offsets and bit positions within STATUS and CLEAR.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  localparam logic [3:0] REG_RXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_CLEAR  = 4'h4;
  localparam logic [3:0] REG_COUNT  = 4'h6;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVR       = 2;
  localparam int unsigned STAT_FERR      = 3;

  localparam int unsigned CLR_OVR  = 0;
  localparam int unsigned CLR_FERR = 1;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial deserializer.
// Ports:
//   clk, rst   - system clock, asynchronous active-low reset
//   rx         - serial line, idle high, asynchronous to clk
//   data       - last received byte (valid alongside the valid pulse)
//   valid      - one-cycle pulse: frame with a good stop bit received
//   frame_err  - one-cycle pulse: stop bit sampled low, byte discarded
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic          rx_m, rx_s, rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Preset to 1 so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Edge (not level) detection: a line stuck low after a framing
          // error cannot start a new frame until it has gone high again.
          if (rx_prev && !rx_s) begin
            cnt   <= HALF_BIT;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt     <= FULL_BIT;
              bit_idx <= '0;
              state   <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_uart_rx.sv
// UART receive peripheral for the J1 I/O bus: receiver core, byte FIFO,
// sticky error flags and register decode.
// Ports:
//   clk, rst          - system clock, asynchronous active-low reset
//   cs, addr, rd, wr  - bus select, register offset and strobes
//   d_in              - bus write data
//   d_out             - registered read data, held until the next read
//   uart_rx           - serial input
//   rx_irq            - registered: FIFO non-empty or an error flag set
module peripheral_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wptr, rptr, count;
  logic        not_empty, full, push, pop, clear;
  logic        ovr, ferr;
  logic        unused_d_in;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  assign count     = wptr - rptr;
  assign not_empty = (count != '0);
  assign full      = (count == (PW + 1)'(FIFO_DEPTH));
  assign pop       = cs && rd && (addr == REG_RXDATA) && not_empty;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign push      = rx_valid && (!full || pop);
  assign clear     = cs && wr && (addr == REG_CLEAR);
  assign unused_d_in = ^d_in[15:2];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      d_out  <= '0;
      rx_irq <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;

      if (rx_valid && full && !pop)    ovr <= 1'b1;
      else if (clear && d_in[CLR_OVR]) ovr <= 1'b0;

      if (rx_ferr)                      ferr <= 1'b1;
      else if (clear && d_in[CLR_FERR]) ferr <= 1'b0;

      if (cs && rd) begin
        unique case (addr)
          REG_RXDATA: d_out <= not_empty ? {8'h00, mem[rptr[PW-1:0]]} : '0;
          REG_STATUS: d_out <= {12'h000, ferr, ovr, full, not_empty};
          REG_COUNT:  d_out <= 16'(count);
          default:    d_out <= '0;
        endcase
      end

      rx_irq <= not_empty || ovr || ferr;
    end
  end

endmodule
